montgomery_ctrl: RTL

Control FSM for the radix-4 Montgomery multiplier datapath. The datapath holds the A/B/2B/3B/M/2M/3M/C registers, the mpadder and the shifter; this block sequences them.
- Waits for operand pre-computation.
- Runs N_BITS/2 radix-4 iterations, each: C += digit·B, C += q·M, C >>= 2.
- Performs the final conditional subtraction of M.
It issues the adder starts, operand-mux selects and register enables, and signals done.

---
 rtl/montgomery_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/montgomery_ctrl.sv
// Sequencer for the radix-4 Montgomery multiplier datapath.
// It waits for operand pre-computation and then runs ITERS radix-4 steps,
// each step being C += digit*B, C += q*M, C >>= 2. It finishes with a
// conditional subtraction of M. The mpadder, the operand muxes and the
// C/A registers all live in the datapath; this block only drives their
// control strobes.
module montgomery_ctrl #(
  parameter int N_BITS = 1024,
  parameter int CNT_W  = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             prep_done_m,
  input  logic             prep_done_b,
  input  logic [1:0]       a_digit,
  input  logic [1:0]       c_low,
  input  logic [1:0]       m_low,
  input  logic             adder_done,
  input  logic             adder_borrow,
  output logic             start_adder,
  output logic             subtract,
  output logic             op_src,
  output logic [1:0]       op_sel,
  output logic             c_en,
  output logic             c_shift,
  output logic             a_shift,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter
);

  localparam int ITERS = N_BITS / 2;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  typedef enum logic [3:0] {
    IDLE, PREP, ITER_B, WAIT_B, CALC_Q, ITER_M, WAIT_M, SHIFT, FIN_SUB, WAIT_SUB, DONE
  } state_t;

  state_t           state_q, state_d;
  logic             flag_m_q, flag_m_d;
  logic             flag_b_q, flag_b_d;
  logic [1:0]       q_q, q_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             err_q, err_d;

  // Low two bits of c*m. Only these bits matter, because q is taken mod 4.
  // With m^-1 == m (mod 4), q = -c*m mod 4 makes C + q*M divisible by 4.
  logic [1:0] cm_lo;
  assign cm_lo = c_low * m_low;

  // State and data registers: reset clears everything, so no run is in flight afterwards
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      flag_m_q <= 1'b0;
      flag_b_q <= 1'b0;
      q_q      <= 2'd0;
      sel_q    <= 2'd0;
      iter_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      flag_m_q <= flag_m_d;
      flag_b_q <= flag_b_d;
      q_q      <= q_d;
      sel_q    <= sel_d;
      iter_q   <= iter_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic and control strobes; the mux selects stay valid through each adder wait
  always_comb begin
    state_d     = state_q;
    flag_m_d    = flag_m_q;
    flag_b_d    = flag_b_q;
    q_d         = q_q;
    sel_d       = sel_q;
    iter_d      = iter_q;
    err_d       = err_q;
    start_adder = 1'b0;
    subtract    = 1'b0;
    op_src      = 1'b0;
    op_sel      = 2'd0;
    c_en        = 1'b0;
    c_shift     = 1'b0;
    a_shift     = 1'b0;
    done        = 1'b0;
    busy        = (state_q != IDLE) && (state_q != DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          // Prep pulses can come in the same cycle as start, so they are captured here too
          flag_m_d = prep_done_m;
          flag_b_d = prep_done_b;
          iter_d   = '0;
          err_d    = 1'b0;
          state_d  = PREP;
        end
      end
      PREP: begin
        flag_m_d = flag_m_q | prep_done_m;
        flag_b_d = flag_b_q | prep_done_b;
        if (flag_m_d && flag_b_d) begin
          flag_m_d = 1'b0;
          flag_b_d = 1'b0;
          err_d    = err_q | ~m_low[0];
          state_d  = ITER_B;
        end
      end
      ITER_B: begin
        if (a_digit != 2'd0) begin
          start_adder = 1'b1;
          op_sel      = a_digit;
          sel_d       = a_digit;
          state_d     = WAIT_B;
        end else begin
          state_d = CALC_Q;
        end
      end
      WAIT_B: begin
        op_sel = sel_q;
        if (adder_done) begin
          c_en    = 1'b1;
          state_d = CALC_Q;
        end
      end
      CALC_Q: begin
        q_d     = 2'd0 - cm_lo;
        state_d = ITER_M;
      end
      ITER_M: begin
        if (q_q != 2'd0) begin
          start_adder = 1'b1;
          op_src      = 1'b1;
          op_sel      = q_q;
          state_d     = WAIT_M;
        end else begin
          state_d = SHIFT;
        end
      end
      WAIT_M: begin
        op_src = 1'b1;
        op_sel = q_q;
        if (adder_done) begin
          c_en    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        c_shift = 1'b1;
        a_shift = 1'b1;
        if (iter_q == LAST_ITER) begin
          state_d = FIN_SUB;
        end else begin
          iter_d  = iter_q + CNT_W'(1);
          state_d = ITER_B;
        end
      end
      FIN_SUB: begin
        start_adder = 1'b1;
        subtract    = 1'b1;
        op_src      = 1'b1;
        op_sel      = 2'd1;
        state_d     = WAIT_SUB;
      end
      WAIT_SUB: begin
        subtract = 1'b1;
        op_src   = 1'b1;
        op_sel   = 2'd1;
        if (adder_done) begin
          // A borrow means C < M, so the unsubtracted C is kept
          c_en    = ~adder_borrow;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err  = err_q;
  assign iter = iter_q;

endmodule
